// File: rtl/instr_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the I-type datapath.
// Optional macro ILLEGAL_HALT_EN: a non-OP-IMM opcode halts the FSM instead of running as a NOP.
module instr_seq_ctrl #(
  parameter int MEM_SIZE = 64,
  parameter int RESET_PC = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tick,
  output logic [31:0] pc,
  input  logic [31:0] instr_data,
  output logic [4:0]  rs1_addr,
  input  logic [31:0] rs1_data,
  output logic [2:0]  alu_func,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic [31:0] last_result,
  output logic [2:0]  state,
  output logic        halted
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4
  } state_t;

  localparam logic [6:0]  OP_IMM     = 7'b0010011;
  localparam logic [31:0] MEM_BOUND  = 32'(MEM_SIZE);
  localparam logic [31:0] PC_AT_RESET = 32'(RESET_PC);

  state_t      cur_state;
  state_t      nxt_state;
  logic [31:0] pc_q;
  logic [31:0] ir;
  logic [31:0] opa;
  logic [31:0] res;
  logic [31:0] last_q;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        opcode_ok;
  logic        commit;

  assign opcode_ok = (ir[6:0] == OP_IMM);
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_next   = (pc_plus4 >= MEM_BOUND) ? 32'd0 : pc_plus4;

  // A write commits only on the WRITEBACK tick of a legal, non-x0 instruction; reset aborts it.
  assign commit = (cur_state == WRITEBACK) && tick && !sys_rst && opcode_ok && (ir[11:7] != 5'd0);

  always_comb begin
    nxt_state = cur_state;
    if (tick) begin
      case (cur_state)
        FETCH:     nxt_state = DECODE;
`ifdef ILLEGAL_HALT_EN
        DECODE:    nxt_state = opcode_ok ? EXECUTE : HALT;
`else
        DECODE:    nxt_state = EXECUTE;
`endif
        EXECUTE:   nxt_state = WRITEBACK;
        WRITEBACK: nxt_state = FETCH;
        HALT:      nxt_state = HALT;
        default:   nxt_state = FETCH;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cur_state <= FETCH;
      pc_q      <= PC_AT_RESET;
      ir        <= 32'd0;
      opa       <= 32'd0;
      res       <= 32'd0;
      last_q    <= 32'd0;
    end else begin
      cur_state <= nxt_state;
      if (tick) begin
        case (cur_state)
          FETCH:   ir  <= instr_data;
          DECODE:  opa <= rs1_data;
          EXECUTE: res <= alu_result;
          WRITEBACK: begin
            pc_q <= pc_next;
            if (commit) last_q <= res;
          end
          default: ;
        endcase
      end
    end
  end

  assign pc          = pc_q;
  assign rs1_addr    = ir[19:15];
  assign alu_func    = ir[14:12];
  assign alu_a       = opa;
  assign alu_b       = {{20{ir[31]}}, ir[31:20]};
  assign rd_addr     = ir[11:7];
  assign rd_wdata    = res;
  assign rd_we       = commit;
  assign last_result = last_q;
  assign state       = cur_state;

`ifdef ILLEGAL_HALT_EN
  assign halted = (cur_state == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Scoreboard bench for instr_seq_ctrl: bench-side program memory, register file and ALU,
// expected register writes queued by the stimulus and matched by a negedge monitor.
module tb_instr_seq_ctrl;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        sys_clk;
  logic        sys_rst;
  logic        tick;
  logic [31:0] pc;
  logic [31:0] instr_data;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;
  logic [2:0]  alu_func;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [31:0] last_result;
  logic [2:0]  state;
  logic        halted;

  logic [31:0] imem [16];
  logic [31:0] regs [32];
  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;

  instr_seq_ctrl #(.MEM_SIZE(64), .RESET_PC(0)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick(tick), .pc(pc),
    .instr_data(instr_data), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .last_result(last_result), .state(state), .halted(halted)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  assign instr_data = imem[4'((pc >> 2) & 32'hF)];
  assign rs1_data   = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];

  // Small reference ALU covering the funct3 codes the program uses.
  always_comb begin
    alu_result = alu_a + alu_b;
    case (alu_func)
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd6:    alu_result = alu_a | alu_b;
      3'd7:    alu_result = alu_a & alu_b;
      default: alu_result = alu_a + alu_b;
    endcase
  end

  always @(posedge sys_clk) begin
    if (rd_we === 1'b1) regs[rd_addr] <= rd_wdata;
  end

  // Monitor: every write pulse must match the oldest queued expectation.
  always @(negedge sys_clk) begin
    if (rd_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got rd=%0d data=%h, required no write", rd_addr, rd_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rd_addr !== e.addr || rd_wdata !== e.data) begin
          errors++;
          $display("[TB] FAIL write: got rd=%0d data=%h, required rd=%0d data=%h",
                   rd_addr, rd_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    @(posedge sys_clk);
    #1 tick = 1'b1;
    repeat (n) @(posedge sys_clk);
    #1 tick = 1'b0;
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic doReset();
    sys_rst = 1'b1;
    tick    = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    imem[0] = 32'h00500093;
    imem[1] = 32'hFFF00113;
    imem[2] = 32'h00700013;
    imem[3] = 32'h00308193;
    for (int i = 4; i < 16; i++) imem[i] = 32'h00120213;
    sys_rst = 1'b1;
    tick    = 1'b0;

    doReset();
    checkOutput("reset_pc", pc, 32'd0);
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_last", last_result, 32'd0);
    checkOutput("reset_halted", 32'(halted), 32'd0);

    // ADDI x1,x0,5
    applyStimulus(3);
    checkOutput("addi5_state", 32'(state), 32'd3);
    checkOutput("addi5_alu_a", alu_a, 32'd0);
    checkOutput("addi5_alu_b", alu_b, 32'd5);
    checkOutput("addi5_func", 32'(alu_func), 32'd0);
    expectWrite(5'd1, 32'd5);
    applyStimulus(1);
    checkOutput("addi5_pc", pc, 32'd4);
    checkOutput("addi5_last", last_result, 32'd5);
    checkOutput("addi5_we_idle", 32'(rd_we), 32'd0);

    // ADDI x2,x0,-1
    applyStimulus(3);
    checkOutput("addim1_alu_b", alu_b, 32'hFFFFFFFF);
    expectWrite(5'd2, 32'hFFFFFFFF);
    applyStimulus(1);
    checkOutput("addim1_pc", pc, 32'd8);
    checkOutput("addim1_last", last_result, 32'hFFFFFFFF);

    // ADDI x0,x0,7 writes nothing
    applyStimulus(4);
    checkOutput("x0_pc", pc, 32'd12);
    checkOutput("x0_last", last_result, 32'hFFFFFFFF);

    // ADDI x3,x1,3 reads back x1
    expectWrite(5'd3, 32'd8);
    applyStimulus(4);
    checkOutput("addi3_pc", pc, 32'd16);
    checkOutput("addi3_last", last_result, 32'd8);

    // Continuous tick over the whole 16-word program
    doReset();
    expectWrite(5'd1, 32'd5);
    expectWrite(5'd2, 32'hFFFFFFFF);
    expectWrite(5'd3, 32'd8);
    for (int k = 1; k <= 12; k++) expectWrite(5'd4, 32'(k));
    @(posedge sys_clk);
    #1 tick = 1'b1;
    for (int k = 0; k < 16; k++) begin
      repeat (4) @(posedge sys_clk);
      #1;
      checkOutput($sformatf("run_pc_%0d", k), pc, 32'(((k + 1) * 4) % 64));
      checkOutput($sformatf("run_state_%0d", k), 32'(state), 32'd0);
    end
    tick = 1'b0;
    checkOutput("run_last", last_result, 32'd12);

    // tick low holds everything
    applyStimulus(1);
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("hold_state", 32'(state), 32'd1);
    checkOutput("hold_pc", pc, 32'd0);

    // Reset in EXECUTE
    applyStimulus(1);
    sys_rst = 1'b1;
    tick    = 1'b1;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    tick = 1'b0;
    checkOutput("rst_exec_state", 32'(state), 32'd0);
    checkOutput("rst_exec_pc", pc, 32'd0);
    checkOutput("rst_exec_last", last_result, 32'd0);

    // Reset on the WRITEBACK tick must suppress the write
    applyStimulus(3);
    checkOutput("rst_wb_state", 32'(state), 32'd3);
    sys_rst = 1'b1;
    tick    = 1'b1;
    #4;
    checkOutput("rst_wb_we", 32'(rd_we), 32'd0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    tick = 1'b0;
    checkOutput("rst_wb_last", last_result, 32'd0);
    checkOutput("rst_wb_pc", pc, 32'd0);

    // Non-OP-IMM opcodes
    imem[1] = 32'h00000033;
    imem[2] = 32'h002081B3;
    doReset();
    expectWrite(5'd1, 32'd5);
    applyStimulus(4);
`ifdef ILLEGAL_HALT_EN
    applyStimulus(2);
    checkOutput("illegal_halted", 32'(halted), 32'd1);
    checkOutput("illegal_state", 32'(state), 32'd4);
    applyStimulus(4);
    checkOutput("illegal_pc_hold", pc, 32'd4);
    checkOutput("illegal_state_hold", 32'(state), 32'd4);
`else
    applyStimulus(4);
    checkOutput("nop_pc", pc, 32'd8);
    checkOutput("nop_halted", 32'(halted), 32'd0);
    applyStimulus(4);
    checkOutput("nop_pc2", pc, 32'd12);
    checkOutput("nop_last", last_result, 32'd5);
    checkOutput("nop_state", 32'(state), 32'd0);
`endif

    repeat (2) @(posedge sys_clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_seq_ctrl.md
Name: instr_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-issue I-type datapath: program memory, register file, ALU and seven-segment result display.
- Owns the program counter and the instruction register. Walks each instruction through FETCH, DECODE, EXECUTE and WRITEBACK, one phase per tick.
- Drives the register-file read/write ports and the ALU operands. Exports the last written result for the display.
- Replaces the free-running PC/combinational path with a controlled, steppable sequence.

Parameters:
- MEM_SIZE, 64, program memory size in bytes; PC wraps to 0 at this bound.
- RESET_PC, 0, PC value after reset; must be a multiple of 4 and less than MEM_SIZE.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- tick  in  1  advance strobe; one FSM phase per cycle in which tick=1
- pc  out  32  current instruction byte address, to program memory
- instr_data  in  32  program memory read data at pc (combinational)
- rs1_addr  out  5  register file read address
- rs1_data  in  32  register file read data (combinational)
- alu_func  out  3  ALU operation (instr[14:12])
- alu_a  out  32  ALU operand A (latched rs1 value)
- alu_b  out  32  ALU operand B (sign-extended imm[11:0])
- alu_result  in  32  ALU result (combinational)
- rd_we  out  1  register file write enable, single-cycle pulse
- rd_addr  out  5  write address (instr[11:7])
- rd_wdata  out  32  write data (latched ALU result)
- last_result  out  32  most recent value written with rd_we=1, to sevenseg
- state  out  3  FSM state code: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, HALT=4
- halted  out  1  high while in HALT

Behaviour:
- Reset values when sys_rst=1 on a clock edge:
  - pc=RESET_PC, state=FETCH.
  - ir=0, opa=0, res=0, last_result=0.
  - rd_we=0, halted=0.
  - tick is ignored.
  - Reset in any state, including mid-WRITEBACK, aborts the instruction with no register write.
- With tick=0, all registers hold and rd_we=0.
- FETCH, tick: ir<=instr_data; go to DECODE.
- DECODE:
  - rs1_addr=ir[19:15] is driven continuously.
  - On tick: opa<=rs1_data; go to EXECUTE.
- EXECUTE:
  - alu_a=opa, alu_b={{20{ir[31]}},ir[31:20]}, alu_func=ir[14:12] are driven continuously in all states after FETCH.
  - On tick: res<=alu_result; go to WRITEBACK.
- WRITEBACK, tick:
  - rd_we=1 combinationally for that cycle only, if rd_addr!=0.
  - rd_wdata=res.
  - If rd_addr!=0, last_result<=res.
  - pc<=pc+4, or 0 if pc+4>=MEM_SIZE.
  - Go to FETCH.
- Latency: exactly 4 ticks per instruction. Continuous tick=1 gives one instruction per 4 clocks.
- rd_addr=0: no rd_we pulse, last_result unchanged, PC still advances.
- Opcode check (ir[6:0]!=7'b0010011) is made in DECODE on tick; see the Optional Feature.
- HALT is absorbing: tick is ignored, pc holds, rd_we=0. Only sys_rst exits it.
- pc arithmetic is 32-bit unsigned. MEM_SIZE need not be a power of 2.

Optional Feature:
- Macro: ILLEGAL_HALT_EN.
- Defined: a non-OP-IMM opcode seen in DECODE on tick sends the FSM to HALT; halted=1 from the next cycle.
- Undefined: a non-OP-IMM instruction is a NOP. It runs all 4 phases, rd_we is suppressed in WRITEBACK, and pc advances normally. halted is tied to 0 and HALT is unreachable.

Test Plan:
- ADDI x1,x0,5 (0x00500093) at pc=0, rs1_data=0, bench ALU a+b:
  - after 3 ticks: alu_a=0, alu_b=5, alu_func=0;
  - 4th tick: rd_we=1 for one cycle, rd_addr=1, rd_wdata=5;
  - then pc=4, last_result=5.
- ADDI x2,x0,-1 (0xFFF00113):
  - alu_b=0xFFFFFFFF;
  - WRITEBACK writes 0xFFFFFFFF to rd=2.
- 16 OP-IMM instructions with tick held high, MEM_SIZE=64:
  - pc goes 0,4,...,60,0;
  - each instruction takes exactly 4 clocks.
- ADDI x0,x0,7 (0x00700013):
  - no rd_we pulse, last_result unchanged;
  - pc still advances by 4.
- sys_rst=1 in EXECUTE with tick=1:
  - next cycle state=FETCH, pc=RESET_PC, last_result=0;
  - no rd_we pulse occurs.
- Opcode 0x00000033:
  - with ILLEGAL_HALT_EN: after the 2nd tick halted=1 and state=4; further ticks leave pc unchanged;
  - without it: 4 ticks, no rd_we, pc+=4.
